// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the addr/wdata/wr_rd/valid/rdata/ready interface.
// Captures a request in IDLE, holds ready low for WAIT_STATES cycles, then
// completes the transfer with a one-cycle ready pulse. Reads return rdata
// with the pulse. Saturating counters track completed writes and reads.
//
// ADDR_WIDTH / WIDTH default to 8 / 16 and are overridden per instance.
// Optional feature, macro MEM_RESP_ERR_EN: adds an err output that flags an
// out-of-range access during its ACK cycle, and such accesses are then not
// counted. Without the macro, out-of-range accesses complete silently.
// -----------------------------------------------------------------------------

module mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  wr_rd,
  input  logic                  valid,
  output logic [WIDTH-1:0]      rdata,
  output logic                  ready,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic [CNT_WIDTH-1:0]  rd_cnt
`ifdef MEM_RESP_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int                  MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [3:0]          LP_WAIT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_e;

  state_e                r_state;
  logic [3:0]            r_wcnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_ready;
  logic [WIDTH-1:0]      r_rdata;
  logic [CNT_WIDTH-1:0]  r_wr_cnt;
  logic [CNT_WIDTH-1:0]  r_rd_cnt;
  logic [WIDTH-1:0]      r_mem [DEPTH];
`ifdef MEM_RESP_ERR_EN
  logic                  r_err;
`endif

  logic                  w_go_ack;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic                  w_req_wr;
  logic [WIDTH-1:0]      w_req_wdata;
  logic                  w_in_range;
  logic [MEM_AW-1:0]     w_mem_idx;
  logic                  w_cnt_en;

  // The edge that enters ACK: straight from IDLE when there are no wait
  // states, otherwise from WAIT on the last counted cycle with valid held.
  assign w_go_ack = ((r_state == S_IDLE) && valid && (WAIT_STATES == 0)) ||
                    ((r_state == S_WAIT) && valid && (r_wcnt == 4'd1));

  // With no wait states the ACK-entry edge is also the capture edge, so the
  // live bus is used there; in WAIT only the latched request matters.
  assign w_req_addr  = (r_state == S_IDLE) ? addr  : r_addr;
  assign w_req_wr    = (r_state == S_IDLE) ? wr_rd : r_wr;
  assign w_req_wdata = (r_state == S_IDLE) ? wdata : r_wdata;

  assign w_in_range = ({1'b0, w_req_addr} < LP_DEPTH);
  assign w_mem_idx  = w_req_addr[MEM_AW-1:0];

`ifdef MEM_RESP_ERR_EN
  assign w_cnt_en = w_in_range;
`else
  assign w_cnt_en = 1'b1;
`endif

  // Transfer FSM with registered ready/rdata/counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching real flop behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_wcnt   <= '0;
      r_addr   <= '0;
      r_wr     <= 1'b0;
      r_wdata  <= '0;
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
`ifdef MEM_RESP_ERR_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_ready <= w_go_ack;
`ifdef MEM_RESP_ERR_EN
      r_err   <= w_go_ack && !w_in_range;
`endif
      case (r_state)
        S_IDLE: begin
          if (valid) begin
            r_addr  <= addr;
            r_wr    <= wr_rd;
            r_wdata <= wdata;
            r_wcnt  <= LP_WAIT;
            r_state <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt - 4'd1;
          if (!valid) begin
            r_state <= S_IDLE;
          end else if (r_wcnt == 4'd1) begin
            r_state <= S_ACK;
          end
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_go_ack && !w_req_wr) begin
        r_rdata <= w_in_range ? r_mem[w_mem_idx] : '0;
      end
      if (w_go_ack && w_req_wr && w_cnt_en && (r_wr_cnt != '1)) begin
        r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
      end
      if (w_go_ack && !w_req_wr && w_cnt_en && (r_rd_cnt != '1)) begin
        r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Storage array written on the ACK-entry edge of an in-range write.
  // NOTE: the array has no reset so it maps onto plain RAM and keeps its
  // contents across reset.
  always_ff @(posedge clk) begin
    if (w_go_ack && w_req_wr && w_in_range) begin
      r_mem[w_mem_idx] <= w_req_wdata;
    end
  end

  assign ready  = r_ready;
  assign rdata  = r_rdata;
  assign wr_cnt = r_wr_cnt;
  assign rd_cnt = r_rd_cnt;
`ifdef MEM_RESP_ERR_EN
  assign err    = r_err;
`endif

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_responder
// Two responders: A (WAIT_STATES=2, DEPTH=128, CNT_WIDTH=4) runs a vector
// table of transfers, an abort, a mid-WAIT reset and a counter saturation
// run; B (WAIT_STATES=0) runs back-to-back transfers with valid held high.
// Expected results are queued when a request is driven and compared when
// the responder raises ready.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int AW      = 8;
  localparam int DW      = 16;
  localparam int WS_A    = 2;
  localparam int DEPTH_A = 128;
  localparam int CW_A    = 4;
  localparam int MAX_A   = (1 << CW_A) - 1;
  localparam int WS_B    = 0;
  localparam int CW_B    = 16;
  localparam int MAX_B   = (1 << CW_B) - 1;

  typedef enum logic [1:0] {OP_XFER, OP_ABORT, OP_RESET} op_e;

  typedef struct {
    op_e         op;
    bit          wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    bit          oor;
    bit          scr;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [15:0] exp_rdata;
    bit          oor;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_a, rst_b;
  logic [AW-1:0]   addr_a, addr_b;
  logic [DW-1:0]   wdata_a, wdata_b, rdata_a, rdata_b;
  logic            wr_a, wr_b, valid_a, valid_b, ready_a, ready_b;
  logic [CW_A-1:0] wr_cnt_a, rd_cnt_a;
  logic [CW_B-1:0] wr_cnt_b, rd_cnt_b;
`ifdef MEM_RESP_ERR_EN
  logic            err_a, err_b;
`endif

  mem_responder #(
    .ADDR_WIDTH(AW), .WIDTH(DW), .DEPTH(DEPTH_A), .WAIT_STATES(WS_A), .CNT_WIDTH(CW_A)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .addr(addr_a), .wdata(wdata_a), .wr_rd(wr_a),
    .valid(valid_a), .rdata(rdata_a), .ready(ready_a),
    .wr_cnt(wr_cnt_a), .rd_cnt(rd_cnt_a)
`ifdef MEM_RESP_ERR_EN
    , .err(err_a)
`endif
  );

  mem_responder #(
    .ADDR_WIDTH(AW), .WIDTH(DW), .DEPTH(256), .WAIT_STATES(WS_B), .CNT_WIDTH(CW_B)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .addr(addr_b), .wdata(wdata_b), .wr_rd(wr_b),
    .valid(valid_b), .rdata(rdata_b), .ready(ready_b),
    .wr_cnt(wr_cnt_b), .rd_cnt(rd_cnt_b)
`ifdef MEM_RESP_ERR_EN
    , .err(err_b)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];
  int          m_wr_a = 0, m_rd_a = 0, m_wr_b = 0, m_rd_b = 0;
  logic [15:0] last_rd_a = '0, last_rd_b = '0;
  vec_t        vec_a [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? v : v + 1;
  endfunction

  // Scoreboard for responder A: compare every ready pulse with the queue.
  always @(negedge clk) begin : mon_a
    exp_t e;
    bit   cnt_en;
    if (rst_a && ready_a) begin
      if (q_a.size() == 0) begin
        check("a_spurious_ready", 32'(ready_a), 32'd0);
      end else begin
        e = q_a.pop_front();
        cnt_en = 1'b1;
`ifdef MEM_RESP_ERR_EN
        cnt_en = !e.oor;
        check("a_err", 32'(err_a), 32'(e.oor));
`endif
        if (e.wr) begin
          if (cnt_en) m_wr_a = sat_inc(m_wr_a, MAX_A);
          check("a_rdata_held_on_write", 32'(rdata_a), 32'(last_rd_a));
        end else begin
          if (cnt_en) m_rd_a = sat_inc(m_rd_a, MAX_A);
          check("a_rdata", 32'(rdata_a), 32'(e.exp_rdata));
          last_rd_a = e.exp_rdata;
        end
        check("a_wr_cnt", 32'(wr_cnt_a), 32'(m_wr_a));
        check("a_rd_cnt", 32'(rd_cnt_a), 32'(m_rd_a));
      end
    end
  end

  // Scoreboard for responder B.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_b && ready_b) begin
      if (q_b.size() == 0) begin
        check("b_spurious_ready", 32'(ready_b), 32'd0);
      end else begin
        e = q_b.pop_front();
`ifdef MEM_RESP_ERR_EN
        check("b_err", 32'(err_b), 32'(e.oor));
`endif
        if (e.wr) begin
          m_wr_b = sat_inc(m_wr_b, MAX_B);
          check("b_rdata_held_on_write", 32'(rdata_b), 32'(last_rd_b));
        end else begin
          m_rd_b = sat_inc(m_rd_b, MAX_B);
          check("b_rdata", 32'(rdata_b), 32'(e.exp_rdata));
          last_rd_b = e.exp_rdata;
        end
        check("b_wr_cnt", 32'(wr_cnt_b), 32'(m_wr_b));
        check("b_rd_cnt", 32'(rd_cnt_b), 32'(m_rd_b));
      end
    end
  end

  // One complete transfer on A; optionally scrambles the bus during WAIT.
  task automatic xfer_a(input bit wr, input logic [7:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd, input bit oor, input bit scr);
    exp_t e;
    int   n;
    e.wr = wr; e.exp_rdata = exp_rd; e.oor = oor;
    q_a.push_back(e);
    valid_a = 1'b1; wr_a = wr; addr_a = a; wdata_a = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scr && !ready_a) begin
        addr_a = ~a; wdata_a = ~d; wr_a = ~wr;
      end
    end while (!ready_a && n < 20);
    check("a_latency", n, WS_A + 1);
    valid_a = 1'b0;
    @(negedge clk);
    check("a_ready_one_cycle", 32'(ready_a), 32'd0);
  endtask

  // Request dropped after one cycle in WAIT: no ack, counters unchanged.
  task automatic abort_a(input vec_t v);
    valid_a = 1'b1; wr_a = v.wr; addr_a = v.addr; wdata_a = v.wdata;
    @(negedge clk);
    valid_a = 1'b0;
    @(negedge clk);
    check("abort_no_ready_1", 32'(ready_a), 32'd0);
    @(negedge clk);
    check("abort_no_ready_2", 32'(ready_a), 32'd0);
    check("abort_wr_cnt", 32'(wr_cnt_a), 32'(m_wr_a));
    check("abort_rd_cnt", 32'(rd_cnt_a), 32'(m_rd_a));
  endtask

  // Asynchronous reset asserted while a write sits in WAIT.
  task automatic reset_a(input vec_t v);
    valid_a = 1'b1; wr_a = v.wr; addr_a = v.addr; wdata_a = v.wdata;
    @(negedge clk);
    #1 rst_a = 1'b0;
    #1;
    check("rst_mid_ready", 32'(ready_a), 32'd0);
    check("rst_mid_rdata", 32'(rdata_a), 32'd0);
    check("rst_mid_wr_cnt", 32'(wr_cnt_a), 32'd0);
    check("rst_mid_rd_cnt", 32'(rd_cnt_a), 32'd0);
    m_wr_a = 0; m_rd_a = 0; last_rd_a = '0;
    valid_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  initial begin
    int n;
    exp_t e;

    vec_a = '{
      '{OP_XFER,  1'b1, 8'h20, 16'h0000, 16'h0000, 1'b0, 1'b0},
      '{OP_XFER,  1'b1, 8'h30, 16'h0000, 16'h0000, 1'b0, 1'b0},
      '{OP_XFER,  1'b1, 8'h10, 16'hA5A5, 16'h0000, 1'b0, 1'b0},
      '{OP_XFER,  1'b0, 8'h10, 16'h0000, 16'hA5A5, 1'b0, 1'b0},
      '{OP_ABORT, 1'b1, 8'h20, 16'h1234, 16'h0000, 1'b0, 1'b0},
      '{OP_XFER,  1'b0, 8'h20, 16'h0000, 16'h0000, 1'b0, 1'b0},
      '{OP_XFER,  1'b0, 8'h10, 16'h0000, 16'hA5A5, 1'b0, 1'b1},
      '{OP_RESET, 1'b1, 8'h30, 16'h5678, 16'h0000, 1'b0, 1'b0},
      '{OP_XFER,  1'b0, 8'h30, 16'h0000, 16'h0000, 1'b0, 1'b0},
      '{OP_XFER,  1'b0, 8'h10, 16'h0000, 16'hA5A5, 1'b0, 1'b0},
      '{OP_XFER,  1'b1, 8'h90, 16'hBEEF, 16'h0000, 1'b1, 1'b0},
      '{OP_XFER,  1'b0, 8'h90, 16'h0000, 16'h0000, 1'b1, 1'b0},
      '{OP_XFER,  1'b1, 8'h7F, 16'h7777, 16'h0000, 1'b0, 1'b1},
      '{OP_XFER,  1'b0, 8'h7F, 16'h0000, 16'h7777, 1'b0, 1'b0},
      '{OP_XFER,  1'b1, 8'h80, 16'h8888, 16'h0000, 1'b1, 1'b0},
      '{OP_XFER,  1'b0, 8'h80, 16'h0000, 16'h0000, 1'b1, 1'b0}
    };

    valid_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
    valid_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    #1 rst_a = 1'b0; rst_b = 1'b0;
    #11;
    check("reset_a_ready", 32'(ready_a), 32'd0);
    check("reset_a_rdata", 32'(rdata_a), 32'd0);
    check("reset_a_wr_cnt", 32'(wr_cnt_a), 32'd0);
    check("reset_a_rd_cnt", 32'(rd_cnt_a), 32'd0);
    check("reset_b_ready", 32'(ready_b), 32'd0);
    check("reset_b_rdata", 32'(rdata_b), 32'd0);
    check("reset_b_wr_cnt", 32'(wr_cnt_b), 32'd0);
    check("reset_b_rd_cnt", 32'(rd_cnt_b), 32'd0);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;

    // B: zero wait states, valid held high across four writes then four
    // reads of 0x00..0x03; ready must come every second cycle.
    valid_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_b    = (i < 4);
      addr_b  = 8'(i % 4);
      wdata_b = 16'(16'h1111 * (i % 4 + 1));
      e.wr = wr_b; e.exp_rdata = 16'(16'h1111 * (i % 4 + 1)); e.oor = 1'b0;
      q_b.push_back(e);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ready_b && n < 20);
      check("b_ready_spacing", n, (i == 0) ? WS_B + 1 : WS_B + 2);
    end
    valid_b = 1'b0;
    @(negedge clk);
    check("b_ready_one_cycle", 32'(ready_b), 32'd0);

    // A: vector table.
    for (int i = 0; i < 16; i++) begin
      case (vec_a[i].op)
        OP_XFER:  xfer_a(vec_a[i].wr, vec_a[i].addr, vec_a[i].wdata,
                         vec_a[i].exp_rd, vec_a[i].oor, vec_a[i].scr);
        OP_ABORT: abort_a(vec_a[i]);
        OP_RESET: reset_a(vec_a[i]);
        default:  ;
      endcase
    end

    // A: saturate the 4-bit write counter, then read back the last value.
    for (int i = 0; i < 17; i++) begin
      xfer_a(1'b1, 8'h40, 16'(i), 16'h0000, 1'b0, 1'b0);
    end
    check("a_wr_cnt_saturated", 32'(wr_cnt_a), 32'h0000_000F);
    xfer_a(1'b0, 8'h40, 16'h0000, 16'd16, 1'b0, 1'b0);

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
